// File: rtl/uart_product_tx.sv
// UART 8N1 transmitter for the multiplier result: sends a sign character, then the
// product high byte and low byte, as three back-to-back frames on one line.
module uart_product_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [15:0] product,
    input  logic        sign,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] prod_q, prod_d;
    logic        sign_q, sign_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        prod_d  = prod_q;
        sign_d  = sign_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (send) begin
                    prod_d  = product;
                    sign_d  = sign;
                    shift_d = sign ? CHAR_MINUS : CHAR_PLUS;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q < 2'd2) begin
                        // Next byte goes straight into a start bit: no idle gap between frames.
                        byte_d  = byte_q + 2'd1;
                        shift_d = (byte_q == 2'd0) ? prod_q[15:8] : prod_q[7:0];
                        state_d = START;
                    end else begin
                        byte_d  = 2'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line and busy are registered from the next state so they change exactly at the edge.
        busy_d = (state_d != IDLE);
        tx_d   = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            shift_q <= 8'd0;
            prod_q  <= 16'd0;
            sign_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            prod_q  <= prod_d;
            sign_q  <= sign_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_product_tx.sv
// Bench for uart_product_tx: a line monitor decodes frames and compares them against
// an expected-frame queue filled when each message is requested.
module tb_uart_product_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [15:0] product = 16'd0;
    logic        sign = 1'b0;
    logic        sel = 1'b0;
    int          cpb = 4;

    logic tx4, busy4, done4, tx2, busy2, done2;
    logic send4, send2, tx_m, busy_m, done_m;

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0] exp_q[$];
    logic [9:0] rx_log[$];

    assign send4  = send & ~sel;
    assign send2  = send & sel;
    assign tx_m   = sel ? tx2 : tx4;
    assign busy_m = sel ? busy2 : busy4;
    assign done_m = sel ? done2 : done4;

    uart_product_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .send(send4), .product(product), .sign(sign),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    uart_product_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .send(send2), .product(product), .sign(sign),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic push_msg(input logic [15:0] p, input logic s);
        exp_q.push_back(frame_of(s ? 8'h2D : 8'h2B));
        exp_q.push_back(frame_of(p[15:8]));
        exp_q.push_back(frame_of(p[7:0]));
    endtask

    // Line monitor: detects a start bit, samples every bit at its middle, compares the frame.
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_frame = '0;

    always @(negedge clk) begin
        if (!mon_active) begin
            if (busy_m && tx_m == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
                mon_frame = '0;
            end
        end else if (!busy_m) begin
            mon_active = 1'b0;
        end else begin
            mon_cnt++;
            if (mon_cnt % cpb == cpb / 2) begin
                mon_frame[mon_cnt / cpb] = tx_m;
                if (mon_cnt / cpb == 9) begin
                    mon_active = 1'b0;
                    rx_log.push_back(mon_frame);
                    check_eq("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check_eq("frame", mon_frame, exp_q.pop_front());
                end
            end
        end
    end

    // One message: optional mid-transfer send/product poke, optional one-cycle reset.
    task automatic run_msg(input logic [15:0] p, input logic s, input int poke, input int rst_at);
        int busy_cnt, done_cnt, overlap, low_run, post_busy;
        bit fin, seen_high;
        busy_cnt = 0; done_cnt = 0; overlap = 0; low_run = 0; post_busy = 0;
        fin = 1'b0; seen_high = 1'b0;
        rx_log.delete();
        check_eq("idle_busy", busy_m, 0);
        @(posedge clk); #1;
        product = p; sign = s; send = 1'b1;
        push_msg(p, s);
        @(posedge clk); #1;
        send = 1'b0;
        check_eq("accept_tx", tx_m, 0);
        check_eq("accept_busy", busy_m, 1);
        for (int c = 0; c < 40 * cpb && !fin; c++) begin
            @(negedge clk);
            if (busy_m) busy_cnt++;
            if (busy_m && done_m) overlap++;
            if (done_m) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (tx_m) seen_high = 1'b1;
            else if (!seen_high) low_run++;
            if (c == poke) begin
                send = 1'b1; product = 16'hAAAA; sign = 1'b1;
            end
            if (c == poke + 1) send = 1'b0;
            if (c == rst_at) rst_n = 1'b0;
            if (c == rst_at + 1) begin
                rst_n = 1'b1;
                check_eq("rst_tx", tx_m, 1);
                check_eq("rst_busy", busy_m, 0);
                check_eq("rst_done", done_m, 0);
                exp_q.delete();
                return;
            end
        end
        check_eq("done_seen", done_cnt, 1);
        check_eq("busy_cycles", busy_cnt, 30 * cpb);
        check_eq("done_busy_overlap", overlap, 0);
        check_eq("start_bit_len", low_run, cpb);
        @(negedge clk);
        check_eq("done_width", done_m, 0);
        check_eq("end_tx_idle", tx_m, 1);
        repeat (12 * cpb) begin
            @(negedge clk);
            if (busy_m || done_m) post_busy++;
        end
        check_eq("no_second_msg", post_busy, 0);
        check_eq("frames_left", exp_q.size(), 0);
    endtask

    // send held high: three back-to-back messages, then released in the third done cycle.
    task automatic run_hold();
        int rise[$];
        int dn[$];
        int msgs, post_busy;
        bit prev_busy;
        msgs = 0; post_busy = 0; prev_busy = 1'b0;
        @(posedge clk); #1;
        product = 16'h8001; sign = 1'b1; send = 1'b1;
        repeat (3) push_msg(16'h8001, 1'b1);
        for (int c = 0; c < 4 * (30 * cpb + 1) && msgs < 3; c++) begin
            @(negedge clk);
            if (busy_m && !prev_busy) begin
                rise.push_back(c);
                check_eq("hold_start_tx", tx_m, 0);
            end
            if (done_m) begin
                dn.push_back(c);
                msgs++;
                if (msgs == 3) send = 1'b0;
            end
            prev_busy = busy_m;
        end
        check_eq("hold_msgs", msgs, 3);
        check_eq("hold_rises", rise.size(), 3);
        for (int i = 1; i < rise.size() && i <= dn.size(); i++) begin
            check_eq("hold_done_to_start", rise[i] - dn[i-1], 1);
            check_eq("hold_period", rise[i] - rise[i-1], 30 * cpb + 1);
        end
        repeat (12 * cpb) begin
            @(negedge clk);
            if (busy_m) post_busy++;
        end
        check_eq("hold_released", post_busy, 0);
        check_eq("hold_frames_left", exp_q.size(), 0);
    endtask

    initial begin
        int tx_low;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_tx4", tx4, 1);
        check_eq("reset_busy4", busy4, 0);
        check_eq("reset_done4", done4, 0);
        check_eq("reset_tx2", tx2, 1);
        check_eq("reset_busy2", busy2, 0);
        check_eq("reset_done2", done2, 0);

        // Baseline message.
        run_msg(16'h000A, 1'b0, 1000000, 1000000);

        // Negative result; byte1 bit pattern checked explicitly.
        run_msg(16'h1234, 1'b1, 1000000, 1000000);
        check_eq("log_size_1234", rx_log.size(), 3);
        if (rx_log.size() == 3) check_eq("byte1_pattern", rx_log[1], 10'b1000100100);

        // send and new product while busy must not disturb the message.
        run_msg(16'h00FF, 1'b0, 50, 1000000);

        // Reset mid-transfer, line stays idle, then a clean message.
        run_msg(16'h5A3C, 1'b0, 1000000, 60);
        tx_low = 0;
        repeat (30) begin
            @(negedge clk);
            if (!tx_m || busy_m) tx_low++;
        end
        check_eq("post_reset_idle", tx_low, 0);
        run_msg(16'hC3E7, 1'b1, 1000000, 1000000);

        // Continuous send.
        run_hold();

        // Two clocks per bit on the second instance.
        @(negedge clk);
        sel = 1'b1;
        cpb = 2;
        run_msg(16'hFFFF, 1'b0, 1000000, 1000000);
        run_msg(16'h0180, 1'b1, 1000000, 1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
